// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline register with writeback select and a
//            retired-instruction counter for the 5-stage MIPS pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      mem_valid,
  input  logic                      mem_reg_write,
  input  logic                      mem_to_reg,
  input  logic [DATA_WIDTH-1:0]     mem_alu_result,
  input  logic [DATA_WIDTH-1:0]     mem_read_data,
  input  logic [REG_ADDR_WIDTH-1:0] mem_write_reg,
  output logic                      wb_valid,
  output logic                      reg_write,
  output logic [REG_ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [CNT_WIDTH-1:0]      retired_count
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  logic                      r_wb_valid;
  logic                      r_reg_write;
  logic [REG_ADDR_WIDTH-1:0] r_write_reg;
  logic [DATA_WIDTH-1:0]     r_result;
  logic [CNT_WIDTH-1:0]      r_retired_count;

  logic                      w_reg_write;
  logic [DATA_WIDTH-1:0]     w_result;

  // Register $0 is hardwired to zero, so writes to it never reach the file.
  assign w_reg_write = mem_valid & mem_reg_write & (mem_write_reg != '0);
  assign w_result    = mem_to_reg ? mem_read_data : mem_alu_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid      <= 1'b0;
      r_reg_write     <= 1'b0;
      r_write_reg     <= '0;
      r_result        <= '0;
      r_retired_count <= '0;
    end else if (flush) begin
      r_wb_valid      <= 1'b0;
      r_reg_write     <= 1'b0;
      r_write_reg     <= '0;
      r_result        <= '0;
    end else if (!stall) begin
      r_wb_valid      <= mem_valid;
      r_reg_write     <= w_reg_write;
      r_write_reg     <= mem_write_reg;
      r_result        <= w_result;
      if (mem_valid) begin
        r_retired_count <= r_retired_count + c_cnt_one;
      end
    end
  end

  assign wb_valid      = r_wb_valid;
  assign reg_write     = r_reg_write;
  assign write_reg     = r_write_reg;
  assign result        = r_result;
  assign retired_count = r_retired_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Scoreboard bench for mem_wb_stage (4-bit counter build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  localparam int c_dw = 32;
  localparam int c_aw = 5;
  localparam int c_cw = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall = 1'b0;
  logic            flush = 1'b0;
  logic            mem_valid = 1'b0;
  logic            mem_reg_write = 1'b0;
  logic            mem_to_reg = 1'b0;
  logic [c_dw-1:0] mem_alu_result = '0;
  logic [c_dw-1:0] mem_read_data = '0;
  logic [c_aw-1:0] mem_write_reg = '0;
  logic            wb_valid;
  logic            reg_write;
  logic [c_aw-1:0] write_reg;
  logic [c_dw-1:0] result;
  logic [c_cw-1:0] retired_count;

  mem_wb_stage #(
    .DATA_WIDTH     (c_dw),
    .REG_ADDR_WIDTH (c_aw),
    .CNT_WIDTH      (c_cw)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_to_reg     (mem_to_reg),
    .mem_alu_result (mem_alu_result),
    .mem_read_data  (mem_read_data),
    .mem_write_reg  (mem_write_reg),
    .wb_valid       (wb_valid),
    .reg_write      (reg_write),
    .write_reg      (write_reg),
    .result         (result),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned v;
    int unsigned rw;
    int unsigned wr;
    int unsigned res;
    int unsigned cnt;
  } exp_t;

  exp_t q[$];
  exp_t m = '{0, 0, 0, 0, 0};
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Reference behaviour of the stage: one entry per clock edge.
  task automatic step(input bit rst_i, input bit st, input bit fl, input bit v,
                      input bit rw, input bit m2r, input int unsigned alu,
                      input int unsigned rdat, input int unsigned rd);
    @(negedge clk);
    reset          = rst_i;
    stall          = st;
    flush          = fl;
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_to_reg     = m2r;
    mem_alu_result = alu;
    mem_read_data  = rdat;
    mem_write_reg  = c_aw'(rd);
    if (rst_i) begin
      m = '{0, 0, 0, 0, 0};
    end else if (fl) begin
      m.v = 0; m.rw = 0; m.wr = 0; m.res = 0;
    end else if (!st) begin
      m.v   = v;
      m.wr  = rd;
      m.res = m2r ? rdat : alu;
      m.rw  = (v && rw && rd != 0) ? 1 : 0;
      if (v) m.cnt = (m.cnt + 1) % (1 << c_cw);
    end
    q.push_back(m);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wb_valid",      wb_valid,      e.v);
      chk("reg_write",     reg_write,     e.rw);
      chk("write_reg",     write_reg,     e.wr);
      chk("result",        result,        e.res);
      chk("retired_count", retired_count, e.cnt);
    end
  end

  initial begin
    // reset two cycles, then idle
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ALU op, load, write to $0
    step(0, 0, 0, 1, 1, 0, 32'h0000_002A, 32'h1111_1111, 8);
    step(0, 0, 0, 1, 1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 9);
    step(0, 0, 0, 1, 1, 0, 32'h0000_0077, 32'h0, 0);
    // capture rd=5, stall three cycles with changing inputs, then flush+stall
    step(0, 0, 0, 1, 1, 0, 32'h0000_0005, 32'h0, 5);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 1, 32'h0000_0066, 32'hCAFE_0000 + i, 6);
    step(0, 1, 1, 1, 1, 0, 32'h0000_0066, 32'h0, 6);
    // drive the 4-bit counter across its wrap, then reset during a stall
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 1, 0, i, 32'h0, (i % 31) + 1);
    step(0, 1, 0, 1, 1, 0, 32'h0000_00AA, 32'h0, 3);
    step(1, 1, 0, 1, 1, 0, 32'h0000_00AA, 32'h0, 3);
    step(0, 0, 0, 0, 1, 0, 32'h0000_00BB, 32'h0, 4);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 75),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
